mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
// Multiply is shift-add and divide is restoring, both on operand magnitudes,
// with one bit per cycle and a sign fix-up applied when the result is written.
// Optional feature: define MUL_DIV_FAST_PATH_EN so that divide-by-zero and
// signed-overflow requests go straight from IDLE to DONE without iterating.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_dout,
  input  logic [XLEN-1:0] rs2_dout,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd_din,
  output logic [4:0]      rd_out,
  output logic            write_enable
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Two's-complement negation helpers.
  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
    neg_w = {XLEN{1'b0}} - x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] x);
    neg_dw = {(2*XLEN){1'b0}} - x;
  endfunction

  // Fixed result for divide-by-zero (all ones / dividend) and signed
  // overflow (most negative value / zero). op[1] selects the remainder ops.
  function automatic logic [XLEN-1:0] special_result(
    input logic [2:0]      op,
    input logic [XLEN-1:0] dividend,
    input logic            by_zero
  );
    if (by_zero) begin
      special_result = op[1] ? dividend : {XLEN{1'b1}};
    end else begin
      special_result = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  endfunction

  // State and latched request.
  logic [1:0]        state_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [4:0]        rd_r;
  logic              sa_r;
  logic              sb_r;
  logic              dbz_r;
  logic              ovf_r;
  logic [4:0]        cnt_r;
  // Datapath: for multiply acc_r is the product, mcand_r the shifting
  // multiplicand and mplier_r the shifting multiplier. For divide acc_r
  // holds the partial remainder, mcand_r the divisor and mplier_r the
  // dividend that turns into the quotient as bits are shifted in.
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] mcand_r;
  logic [XLEN-1:0]   mplier_r;

  // Request decode from the live inputs, used only at acceptance.
  logic              is_div_s;
  logic              a_sgn_s;
  logic              b_sgn_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              dbz_s;
  logic              ovf_s;
  logic [XLEN-1:0]   spec_res_s;

  // One iteration step and final result.
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] mcand_nxt_s;
  logic [XLEN-1:0]   mplier_nxt_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     divisor_s;
  logic [XLEN:0]     diff_s;
  logic              ge_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   result_s;

  // Decode signedness, magnitudes and the special divide cases of a request.
  always_comb begin
    is_div_s = funct3[2];
    a_sgn_s  = rs1_dout[XLEN-1] &
               ((funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                (funct3 == OP_DIV)  || (funct3 == OP_REM));
    b_sgn_s  = rs2_dout[XLEN-1] &
               ((funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM));
    if (a_sgn_s) begin
      a_mag_s = neg_w(rs1_dout);
    end else begin
      a_mag_s = rs1_dout;
    end
    if (b_sgn_s) begin
      b_mag_s = neg_w(rs2_dout);
    end else begin
      b_mag_s = rs2_dout;
    end
    dbz_s      = is_div_s && (rs2_dout == {XLEN{1'b0}});
    ovf_s      = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                 (rs1_dout == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2_dout == {XLEN{1'b1}});
    spec_res_s = special_result(funct3, rs1_dout, dbz_s);
  end

  // One shift-add or restoring-divide step on the current datapath state.
  always_comb begin
    rem_sh_s  = {acc_r[XLEN-1:0], mplier_r[XLEN-1]};
    divisor_s = {1'b0, mcand_r[XLEN-1:0]};
    diff_s    = rem_sh_s - divisor_s;
    ge_s      = (rem_sh_s >= divisor_s);
    if (op_r[2]) begin
      acc_nxt_s    = {{(XLEN-1){1'b0}}, (ge_s ? diff_s : rem_sh_s)};
      mcand_nxt_s  = mcand_r;
      mplier_nxt_s = {mplier_r[XLEN-2:0], ge_s};
    end else begin
      if (mplier_r[0]) begin
        acc_nxt_s = acc_r + mcand_r;
      end else begin
        acc_nxt_s = acc_r;
      end
      mcand_nxt_s  = {mcand_r[2*XLEN-2:0], 1'b0};
      mplier_nxt_s = {1'b0, mplier_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and op selection applied to the outcome of the last step.
  always_comb begin
    if (sa_r ^ sb_r) begin
      prod_s = neg_dw(acc_nxt_s);
      quo_s  = neg_w(mplier_nxt_s);
    end else begin
      prod_s = acc_nxt_s;
      quo_s  = mplier_nxt_s;
    end
    if (sa_r) begin
      rem_s = neg_w(acc_nxt_s[XLEN-1:0]);
    end else begin
      rem_s = acc_nxt_s[XLEN-1:0];
    end
    case (op_r)
      OP_MUL:                          result_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:    result_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                 result_s = quo_s;
      OP_REM, OP_REMU:                 result_s = rem_s;
      default:                         result_s = {XLEN{1'b0}};
    endcase
    if (dbz_r || ovf_r) begin
      result_s = special_result(op_r, a_r, dbz_r);
    end else begin
      result_s = result_s;
    end
  end

  // Control FSM, request latch, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      op_r         <= 3'b000;
      a_r          <= {XLEN{1'b0}};
      rd_r         <= 5'd0;
      sa_r         <= 1'b0;
      sb_r         <= 1'b0;
      dbz_r        <= 1'b0;
      ovf_r        <= 1'b0;
      cnt_r        <= 5'd0;
      acc_r        <= {(2*XLEN){1'b0}};
      mcand_r      <= {(2*XLEN){1'b0}};
      mplier_r     <= {XLEN{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      write_enable <= 1'b0;
      rd_din       <= {XLEN{1'b0}};
      rd_out       <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          busy         <= 1'b0;
          done         <= 1'b0;
          write_enable <= 1'b0;
          if (start) begin
            op_r  <= funct3;
            a_r   <= rs1_dout;
            rd_r  <= rd;
            sa_r  <= a_sgn_s;
            sb_r  <= b_sgn_s;
            dbz_r <= dbz_s;
            ovf_r <= ovf_s;
            cnt_r <= 5'd0;
            acc_r <= {(2*XLEN){1'b0}};
            if (is_div_s) begin
              mcand_r  <= {{XLEN{1'b0}}, b_mag_s};
              mplier_r <= a_mag_s;
            end else begin
              mcand_r  <= {{XLEN{1'b0}}, a_mag_s};
              mplier_r <= b_mag_s;
            end
`ifdef MUL_DIV_FAST_PATH_EN
            if (dbz_s || ovf_s) begin
              state_r      <= DONE;
              done         <= 1'b1;
              write_enable <= (rd != 5'd0);
              rd_din       <= spec_res_s;
              rd_out       <= rd;
            end else begin
              state_r <= CALC;
              busy    <= 1'b1;
            end
`else
            state_r <= CALC;
            busy    <= 1'b1;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= mcand_nxt_s;
          mplier_r <= mplier_nxt_s;
          if (cnt_r == LAST_ITER) begin
            state_r      <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            write_enable <= (rd_r != 5'd0);
            rd_din       <= result_s;
            rd_out       <= rd_r;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        DONE: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          write_enable <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit with
// hand-computed expected results, latencies and write strobes.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_dout;
  logic [31:0] rs2_dout;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] rd_din;
  logic [4:0]  rd_out;
  logic        write_enable;

  int total_cnt = 0;
  int bad_cnt   = 0;

`ifdef MUL_DIV_FAST_PATH_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  mul_div_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .funct3       (funct3),
    .rs1_dout     (rs1_dout),
    .rs2_dout     (rs2_dout),
    .rd           (rd),
    .busy         (busy),
    .done         (done),
    .rd_din       (rd_din),
    .rd_out       (rd_out),
    .write_enable (write_enable)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge, scramble inputs after acceptance, wait
  // for done and check latency, result, destination and write strobe.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input int lat);
    int  n;
    bit  seen;
    funct3 = f; rs1_dout = a; rs2_dout = b; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; rs1_dout = ~a; rs2_dout = ~b; rd = ~r;
    n = 0; seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, " busy"}, {31'd0, busy}, (lat > 1) ? 32'd1 : 32'd0);
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " rd_din"}, rd_din, exp);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, r});
    check({tag, " we"}, {31'd0, write_enable}, (r != 5'd0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, " done low"}, {31'd0, done}, 32'd0);
    check({tag, " hold"}, rd_din, exp);
  endtask

  initial begin : main
    int n;
    int pulses;
    reset = 1'b1; start = 1'b1; funct3 = 3'b000;
    rs1_dout = 32'd1; rs2_dout = 32'd1; rd = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst we", {31'd0, write_enable}, 32'd0);
    check("rst rd_din", rd_din, 32'd0);
    check("rst rd_out", {27'd0, rd_out}, 32'd0);

    // Multiply family
    run_op("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 33);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000, 33);
    run_op("mulh2",  3'b001, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 33);

    // Divide family
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'h80000000, 32'h00000003, 5'd12, 32'h2AAAAAAA, 33);
    run_op("remu",   3'b111, 32'h00000064, 32'h00000007, 5'd13, 32'h00000002, 33);

    // Special cases
    run_op("div0",   3'b100, 32'h00000005, 32'h00000000, 5'd14, 32'hFFFFFFFF, SPEC_LAT);
    run_op("remu0",  3'b111, 32'h00000005, 32'h00000000, 5'd15, 32'h00000005, SPEC_LAT);
    run_op("divneg0",3'b100, 32'hFFFFFFFB, 32'h00000000, 5'd16, 32'hFFFFFFFF, SPEC_LAT);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, SPEC_LAT);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, SPEC_LAT);

    // rd = 0: done pulses but no write strobe
    run_op("mul rd0", 3'b000, 32'h00000003, 32'h00000004, 5'd0, 32'h0000000C, 33);

    // Start during CALC is ignored and not queued
    funct3 = 3'b000; rs1_dout = 32'd6; rs2_dout = 32'd7; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; pulses = 0;
    while (n < 100 && pulses == 0) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        start = 1'b1; funct3 = 3'b000; rs1_dout = 32'd2; rs2_dout = 32'd2; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) pulses++;
    end
    check("ign latency", n, 33);
    check("ign rd_din", rd_din, 32'h0000002A);
    check("ign rd_out", {27'd0, rd_out}, 32'd3);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("ign not queued", pulses, 0);

    // Reset at cycle 20 of an operation aborts it silently
    funct3 = 3'b101; rs1_dout = 32'd100; rs2_dout = 32'd3; rd = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort rd_din", rd_din, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (write_enable || done) pulses++;
    end
    check("abort no we", pulses, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
